// File: rtl/vga_pkg.sv
// Shared definitions for the scan-out fetch path.
//   AWIDTH_DEF / DWIDTH_DEF        : default VRAM address / data byte widths
//   FRAME_BYTES_DEF / DEPTH_DEF    : default bytes per frame / FIFO entries
//   fetchState_t                   : IDLE / FETCH / DONE fetch state encoding
//   cntWidth()                     : bits needed to count 0..n inclusive
package vga_pkg;

  localparam int AWIDTH_DEF      = 19;
  localparam int DWIDTH_DEF      = 8;
  localparam int FRAME_BYTES_DEF = 38400;
  localparam int DEPTH_DEF       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetchState_t;

  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
//   MemClk  in   clock, rising edge
//   Reset   in   synchronous active-high reset
//   Flush   in   synchronous empty (same effect as Reset on the FIFO)
//   Push    in   write WrData; caller guarantees !Full || Pop
//   WrData  in   DWIDTH write data
//   Pop     in   drop the head entry; caller guarantees Valid
//   RdData  out  head entry (0 while empty)
//   Valid   out  FIFO not empty
//   Full    out  FIFO holds DEPTH entries
//   Level   out  occupancy, 0..DEPTH
module sync_fifo #(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 16,
  localparam int PWIDTH = $clog2(DEPTH),
  localparam int LWIDTH = PWIDTH + 1
) (
  input  logic              MemClk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Push,
  input  logic [DWIDTH-1:0] WrData,
  input  logic              Pop,
  output logic [DWIDTH-1:0] RdData,
  output logic              Valid,
  output logic              Full,
  output logic [LWIDTH-1:0] Level
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PWIDTH-1:0] wrPtrReg;
  logic [PWIDTH-1:0] rdPtrReg;
  logic [PWIDTH-1:0] rdPtrNext;
  logic [LWIDTH-1:0] levelReg;
  logic [DWIDTH-1:0] headReg;

  assign rdPtrNext = Pop ? rdPtrReg + 1'b1 : rdPtrReg;

  always_ff @(posedge MemClk) begin
    if (Push) begin
      mem[wrPtrReg] <= WrData;
    end
  end

  // The head is a registered read of the slot the read pointer will point
  // at after this edge. When that slot is being written right now (push into
  // an empty FIFO, or push while popping the last entry) the array still
  // holds the old value, so the write data is forwarded instead.
  always_ff @(posedge MemClk) begin
    if (Reset || Flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      levelReg <= '0;
      headReg  <= '0;
    end else begin
      if (Push) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      rdPtrReg <= rdPtrNext;
      case ({Push, Pop})
        2'b10:   levelReg <= levelReg + 1'b1;
        2'b01:   levelReg <= levelReg - 1'b1;
        default: levelReg <= levelReg;
      endcase
      headReg <= (Push && (wrPtrReg == rdPtrNext)) ? WrData : mem[rdPtrNext];
    end
  end

  assign Level  = levelReg;
  assign Valid  = (levelReg != '0);
  assign Full   = (levelReg == LWIDTH'(DEPTH));
  // Stale array contents are never exposed while empty.
  assign RdData = Valid ? headReg : '0;

endmodule

// File: rtl/scan_fetch.sv
// Scan-out fetcher: walks FRAME_BYTES consecutive VRAM addresses from BaseAddr,
// buffering returned bytes in a show-ahead FIFO for the pixel consumer.
//   MemClk       in   clock, rising edge
//   Reset        in   synchronous active-high reset (beats FrameStart)
//   FrameStart   in   pulse: restart fetch at BaseAddr, flush FIFO
//   BaseAddr     in   AWIDTH frame base address
//   ReqAddr      out  AWIDTH address presented to the arbiter
//   ReadData     in   DWIDTH byte from the arbiter
//   ReadDataRdy  in   ReadData valid strobe
//   PixelReq     in   consumer pop request
//   PixelData    out  FIFO head
//   PixelValid   out  FIFO not empty
//   Level        out  FIFO occupancy
//   Underrun     out  sticky pop-while-empty flag
// Build option: define SCAN_FETCH_UNDERRUN_EN to implement Underrun detection;
// otherwise Underrun is tied to 0.
module scan_fetch
  import vga_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                     MemClk,
  input  logic                     Reset,
  input  logic                     FrameStart,
  input  logic [AWIDTH-1:0]        BaseAddr,
  output logic [AWIDTH-1:0]        ReqAddr,
  input  logic [DWIDTH-1:0]        ReadData,
  input  logic                     ReadDataRdy,
  input  logic                     PixelReq,
  output logic [DWIDTH-1:0]        PixelData,
  output logic                     PixelValid,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Underrun
);

  localparam int CWIDTH = cntWidth(FRAME_BYTES);

  fetchState_t       stateReg, stateNext;
  logic [AWIDTH-1:0] addrReg, addrNext;
  logic [CWIDTH-1:0] countReg, countNext;
  logic              fifoFull;
  logic              popEn;
  logic              acceptEn;

  // FrameStart wins over both sides: the returned byte and the pop are dropped.
  assign popEn    = PixelReq && PixelValid && !FrameStart;
  // A full FIFO can still take the byte if the consumer frees a slot this cycle;
  // otherwise the address is held so the byte is refetched later.
  assign acceptEn = ReadDataRdy && (stateReg == FETCH) && (!fifoFull || popEn) && !FrameStart;

  always_ff @(posedge MemClk) begin
    if (Reset) begin
      stateReg <= IDLE;
      addrReg  <= '0;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      addrReg  <= addrNext;
      countReg <= countNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    addrNext  = addrReg;
    countNext = countReg;
    if (FrameStart) begin
      stateNext = FETCH;
      addrNext  = BaseAddr;
      countNext = '0;
    end else if (acceptEn) begin
      addrNext  = addrReg + 1'b1;
      countNext = countReg + 1'b1;
      if (countReg == CWIDTH'(FRAME_BYTES - 1)) begin
        stateNext = DONE;
      end
    end
  end

  assign ReqAddr = addrReg;

  sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) pixelFifo (
    .MemClk (MemClk),
    .Reset  (Reset),
    .Flush  (FrameStart),
    .Push   (acceptEn),
    .WrData (ReadData),
    .Pop    (popEn),
    .RdData (PixelData),
    .Valid  (PixelValid),
    .Full   (fifoFull),
    .Level  (Level)
  );

`ifdef SCAN_FETCH_UNDERRUN_EN
  logic underrunReg;

  always_ff @(posedge MemClk) begin
    if (Reset || FrameStart) begin
      underrunReg <= 1'b0;
    end else if (PixelReq && !PixelValid) begin
      underrunReg <= 1'b1;
    end
  end

  assign Underrun = underrunReg;
`else
  assign Underrun = 1'b0;
`endif

endmodule

// File: tb/tb_scan_fetch.sv
// Testbench for scan_fetch: two instances (long frame / 8-byte frame) share
// one stimulus stream; a queue-based model predicts each instance's outputs.
module tb_scan_fetch;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int FB_A  = 40;
  localparam int FB_B  = 8;
`ifdef SCAN_FETCH_UNDERRUN_EN
  localparam bit UND_EN = 1'b1;
`else
  localparam bit UND_EN = 1'b0;
`endif

  logic          MemClk = 1'b0;
  logic          Reset = 1'b1;
  logic          FrameStart = 1'b0;
  logic [AW-1:0] BaseAddr = '0;
  logic [DW-1:0] ReadData = '0;
  logic          ReadDataRdy = 1'b0;
  logic          PixelReq = 1'b0;

  logic [AW-1:0] reqAddrA, reqAddrB;
  logic [DW-1:0] pixDataA, pixDataB;
  logic          pixValidA, pixValidB;
  logic [4:0]    levelA, levelB;
  logic          undA, undB;

  int nVec  = 0;
  int nFail = 0;

  always #5 MemClk = ~MemClk;

  scan_fetch #(.AWIDTH(AW), .DWIDTH(DW), .FRAME_BYTES(FB_A), .DEPTH(DEPTH)) uA (
    .MemClk(MemClk), .Reset(Reset), .FrameStart(FrameStart), .BaseAddr(BaseAddr),
    .ReqAddr(reqAddrA), .ReadData(ReadData), .ReadDataRdy(ReadDataRdy),
    .PixelReq(PixelReq), .PixelData(pixDataA), .PixelValid(pixValidA),
    .Level(levelA), .Underrun(undA)
  );

  scan_fetch #(.AWIDTH(AW), .DWIDTH(DW), .FRAME_BYTES(FB_B), .DEPTH(DEPTH)) uB (
    .MemClk(MemClk), .Reset(Reset), .FrameStart(FrameStart), .BaseAddr(BaseAddr),
    .ReqAddr(reqAddrB), .ReadData(ReadData), .ReadDataRdy(ReadDataRdy),
    .PixelReq(PixelReq), .PixelData(pixDataB), .PixelValid(pixValidB),
    .Level(levelB), .Underrun(undB)
  );

  // ---------------- reference model ----------------
  // mState: 0 = idle, 1 = fetching, 2 = frame complete
  int            mState [2];
  logic [AW-1:0] mAddr  [2];
  int            mCount [2];
  bit            mUnd   [2];
  logic [DW-1:0] qA [$];
  logic [DW-1:0] qB [$];

  function automatic int qsize(input int k);
    return (k == 0) ? qA.size() : qB.size();
  endfunction

  function automatic logic [DW-1:0] qhead(input int k);
    return (k == 0) ? qA[0] : qB[0];
  endfunction

  task automatic qpush(input int k, input logic [DW-1:0] d);
    if (k == 0) qA.push_back(d); else qB.push_back(d);
  endtask

  task automatic qdrop(input int k);
    if (k == 0) void'(qA.pop_front()); else void'(qB.pop_front());
  endtask

  task automatic qclear(input int k);
    if (k == 0) qA.delete(); else qB.delete();
  endtask

  task automatic modelStep(input int k);
    int fb;
    bit hadData;
    bit popNow;
    bit room;
    fb = (k == 0) ? FB_A : FB_B;
    if (Reset) begin
      mState[k] = 0; mAddr[k] = '0; mCount[k] = 0; mUnd[k] = 1'b0; qclear(k);
    end else if (FrameStart) begin
      mState[k] = 1; mAddr[k] = BaseAddr; mCount[k] = 0; mUnd[k] = 1'b0; qclear(k);
    end else begin
      hadData = (qsize(k) > 0);
      popNow  = PixelReq && hadData;
      room    = (qsize(k) < DEPTH);
      if (PixelReq && !hadData && UND_EN) mUnd[k] = 1'b1;
      if (popNow) qdrop(k);
      if (ReadDataRdy && mState[k] == 1 && (room || popNow)) begin
        qpush(k, ReadData);
        mAddr[k]  = mAddr[k] + 1'b1;
        mCount[k] = mCount[k] + 1;
        if (mCount[k] == fb) mState[k] = 2;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkInst(input int k, input logic [AW-1:0] a, input logic [4:0] lv,
                           input logic v, input logic [DW-1:0] d, input logic u);
    string s;
    s = (k == 0) ? "A" : "B";
    chk({s, ".ReqAddr"},    32'(a),  32'(mAddr[k]));
    chk({s, ".Level"},      32'(lv), 32'(qsize(k)));
    chk({s, ".PixelValid"}, 32'(v),  32'(qsize(k) > 0));
    chk({s, ".PixelData"},  32'(d),  (qsize(k) > 0) ? 32'(qhead(k)) : 32'd0);
    chk({s, ".Underrun"},   32'(u),  32'(mUnd[k]));
  endtask

  task automatic step(input bit rst, input bit fs, input logic [AW-1:0] base,
                      input bit rdy, input logic [DW-1:0] d, input bit pr);
    Reset = rst; FrameStart = fs; BaseAddr = base;
    ReadDataRdy = rdy; ReadData = d; PixelReq = pr;
    modelStep(0);
    modelStep(1);
    @(posedge MemClk);
    #1;
    checkInst(0, reqAddrA, levelA, pixValidA, pixDataA, undA);
    checkInst(1, reqAddrB, levelB, pixValidB, pixDataB, undB);
  endtask

  initial begin
    // Reset
    step(1, 0, '0, 0, '0, 0);
    step(1, 0, '0, 1, 8'h55, 1);
    chk("rst.ReqAddr", 32'(reqAddrA), 32'h0);
    chk("rst.Level", 32'(levelA), 32'd0);

    // Frame at 0x01000, four bytes A1..A4
    step(0, 1, 19'h01000, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 8'(8'hA1 + i), 0);
    chk("s1.ReqAddr", 32'(reqAddrA), 32'h01004);
    chk("s1.Level", 32'(levelA), 32'd4);
    chk("s1.PixelData", 32'(pixDataA), 32'hA1);

    // 17 strobes into an empty FIFO, no pops: 17th dropped
    step(0, 1, 19'h02000, 0, '0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, '0, 1, 8'(i + 1), 0);
    chk("s2.Level", 32'(levelA), 32'd16);
    chk("s2.ReqAddr", 32'(reqAddrA), 32'h02010);

    // Full FIFO: strobe plus pop in the same cycle
    step(0, 0, '0, 1, 8'hEE, 1);
    chk("s3.Level", 32'(levelA), 32'd16);
    chk("s3.ReqAddr", 32'(reqAddrA), 32'h02011);
    chk("s3.PixelData", 32'(pixDataA), 32'h02);

    // 8-byte frame, 10 strobes with continuous pops
    step(0, 1, 19'h03000, 0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1, 8'(8'hC0 + i), 1);
    chk("s4.ReqAddr", 32'(reqAddrB), 32'h03008);
    chk("s4.Level", 32'(levelB), 32'd0);

    // Underrun set by pop-while-empty, cleared by FrameStart
    step(0, 1, 19'h04000, 0, '0, 0);
    step(0, 0, '0, 0, '0, 1);
    chk("s5.Underrun", 32'(undA), 32'(UND_EN));
    step(0, 1, 19'h04000, 0, '0, 0);
    chk("s5.UnderrunClr", 32'(undA), 32'd0);

    // FrameStart beats a simultaneous strobe and pop
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 8'(8'h30 + i), 0);
    step(0, 1, 19'h05000, 1, 8'h77, 1);
    chk("s6.Level", 32'(levelA), 32'd0);
    chk("s6.ReqAddr", 32'(reqAddrA), 32'h05000);

    // Address wrap, then reset mid-frame (also beating FrameStart)
    step(0, 1, 19'h7FFFE, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 8'(8'h90 + i), 0);
    chk("s7.ReqAddr", 32'(reqAddrA), 32'h00001);
    step(0, 0, '0, 1, 8'h93, 0);
    step(1, 1, 19'h12345, 1, 8'h94, 1);
    chk("s7.RstLevel", 32'(levelA), 32'd0);
    chk("s7.RstAddr", 32'(reqAddrA), 32'h0);
    step(0, 0, '0, 1, 8'h95, 0);
    chk("s7.IdleLevel", 32'(levelA), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           AW'($urandom_range(0, 19'h7FFFF)), ($urandom_range(0, 1) == 1),
           DW'($urandom), ($urandom_range(0, 9) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
